// File: rtl/tictactoe_pkg.sv
// tictactoe_pkg: shared encodings for the 3x3 game sequencer.
// Cell/state enums, winner codes, win-line table, player toggle.
package tictactoe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        P1    = 2'b01,
        P2    = 2'b10
    } cell_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    typedef enum logic [1:0] {
        PLAY  = 2'b00,
        CHECK = 2'b01,
        OVER  = 2'b10
    } state_t;

    localparam int NUM_CELLS = 9;
    localparam int NUM_LINES = 8;

    // Rows, columns, then the two diagonals (row-major cell index).
    localparam logic [3:0] WIN_LINES [NUM_LINES][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    function automatic cell_t other_player(cell_t p);
        return (p == P1) ? P2 : P1;
    endfunction

endpackage

// File: rtl/button_edge.sv
// button_edge: 2-flop synchroniser plus rising-edge detector.
// Ports: clk, rst (sync, active-high), btn (async level), pulse (1 cycle).
module button_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic sync_1;
    logic sync_2;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            sync_1 <= btn;
            sync_2 <= sync_1;
            prev_q <= sync_2;
        end
    end

    // A held button stays high in sync_2 and prev_q, so only one pulse.
    assign pulse = sync_2 & ~prev_q;

endmodule

// File: rtl/board_controller.sv
// board_controller: 3x3 game sequencer - board, cursor, turn, win/draw, turn timeout.
// Ports: clk, rst, btn_move, btn_place in; block00..block22, selected, turn, winner, game_over, move_count out.
module board_controller
    import tictactoe_pkg::*;
#(
    parameter int unsigned TURN_CYCLES = 500_000_000,
    parameter int          TIMER_W     = 29
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         btn_move,
    input  logic         btn_place,
    output logic [1:0]   block00,
    output logic [1:0]   block01,
    output logic [1:0]   block02,
    output logic [1:0]   block10,
    output logic [1:0]   block11,
    output logic [1:0]   block12,
    output logic [1:0]   block20,
    output logic [1:0]   block21,
    output logic [1:0]   block22,
    output logic [3:0]   selected,
    output logic [1:0]   turn,
    output logic [1:0]   winner,
    output logic         game_over,
    output logic [3:0]   move_count
);

    localparam bit TIMEOUT_EN = (TURN_CYCLES != 0);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TURN_CYCLES - 1);

    cell_t              cells [NUM_CELLS];
    cell_t              turn_q;
    state_t             state;
    logic [TIMER_W-1:0] timer;
    logic               move_pulse;
    logic               place_pulse;
    logic               line_won;

    button_edge u_move (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_move),
        .pulse (move_pulse)
    );

    button_edge u_place (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_place),
        .pulse (place_pulse)
    );

    // Only the mark just placed can close a line, so test the mover only.
    always_comb begin
        line_won = 1'b0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (cells[WIN_LINES[i][0]] == turn_q &&
                cells[WIN_LINES[i][1]] == turn_q &&
                cells[WIN_LINES[i][2]] == turn_q)
                line_won = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CELLS; i++)
                cells[i] <= EMPTY;
            selected   <= 4'd0;
            turn_q     <= P1;
            winner     <= WIN_NONE;
            game_over  <= 1'b0;
            move_count <= 4'd0;
            timer      <= '0;
            state      <= PLAY;
        end else begin
            unique case (state)
                PLAY: begin
                    if (place_pulse && cells[selected] == EMPTY) begin
                        cells[selected] <= turn_q;
                        move_count      <= move_count + 4'd1;
                        timer           <= '0;
                        state           <= CHECK;
                    end else begin
                        // A coincident place pulse swallows the move.
                        if (move_pulse && !place_pulse)
                            selected <= (selected == 4'd8) ? 4'd0 : selected + 4'd1;
                        if (TIMEOUT_EN && timer == TIMER_LAST) begin
                            turn_q <= other_player(turn_q);
                            timer  <= '0;
                        end else begin
                            timer <= timer + TIMER_W'(1);
                        end
                    end
                end
                CHECK: begin
                    if (line_won) begin
                        winner    <= turn_q;
                        game_over <= 1'b1;
                        state     <= OVER;
                    end else if (move_count == 4'd9) begin
                        winner    <= WIN_DRAW;
                        game_over <= 1'b1;
                        state     <= OVER;
                    end else begin
                        turn_q <= other_player(turn_q);
                        timer  <= '0;
                        state  <= PLAY;
                    end
                end
                OVER: begin
                    timer <= '0;
                    if (place_pulse) begin
                        for (int i = 0; i < NUM_CELLS; i++)
                            cells[i] <= EMPTY;
                        selected   <= 4'd0;
                        turn_q     <= P1;
                        winner     <= WIN_NONE;
                        move_count <= 4'd0;
                        game_over  <= 1'b0;
                        state      <= PLAY;
                    end
                end
                default: begin
                    state     <= PLAY;
                    game_over <= 1'b0;
                end
            endcase
        end
    end

    assign block00 = cells[0];
    assign block01 = cells[1];
    assign block02 = cells[2];
    assign block10 = cells[3];
    assign block11 = cells[4];
    assign block12 = cells[5];
    assign block20 = cells[6];
    assign block21 = cells[7];
    assign block22 = cells[8];
    assign turn    = turn_q;

endmodule

// File: tb/tb_board_controller.sv
// tb_board_controller: randomized and directed bench for board_controller.
// Keeps a game-level reference model fed with the same button timeline.
module tb_board_controller;

    localparam int T = 50;

    logic       clk;
    logic       rst;
    logic       btn_move;
    logic       btn_place;
    logic [1:0] b00, b01, b02, b10, b11, b12, b20, b21, b22;
    logic [3:0] selected;
    logic [1:0] turn;
    logic [1:0] winner;
    logic       game_over;
    logic [3:0] move_count;

    board_controller #(.TURN_CYCLES(T), .TIMER_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_move   (btn_move),
        .btn_place  (btn_place),
        .block00    (b00),
        .block01    (b01),
        .block02    (b02),
        .block10    (b10),
        .block11    (b11),
        .block12    (b12),
        .block20    (b20),
        .block21    (b21),
        .block22    (b22),
        .selected   (selected),
        .turn       (turn),
        .winner     (winner),
        .game_over  (game_over),
        .move_count (move_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model: mode 0 = playing, 1 = judging last mark, 2 = finished.
    int m_board [9];
    int m_sel, m_turn, m_win, m_cnt, m_elapsed, m_mode;
    bit last_mv, last_pl, d1_mv, d1_pl, d2_mv, d2_pl;

    function automatic bit m_wins(int p);
        bit w;
        w = 1'b0;
        for (int r = 0; r < 3; r++) begin
            if (m_board[3*r] == p && m_board[3*r+1] == p && m_board[3*r+2] == p) w = 1'b1;
            if (m_board[r] == p && m_board[r+3] == p && m_board[r+6] == p) w = 1'b1;
        end
        if (m_board[0] == p && m_board[4] == p && m_board[8] == p) w = 1'b1;
        if (m_board[2] == p && m_board[4] == p && m_board[6] == p) w = 1'b1;
        return w;
    endfunction

    task automatic m_reset();
        foreach (m_board[i]) m_board[i] = 0;
        m_sel = 0; m_turn = 1; m_win = 0; m_cnt = 0; m_elapsed = 0; m_mode = 0;
        last_mv = 0; last_pl = 0; d1_mv = 0; d1_pl = 0; d2_mv = 0; d2_pl = 0;
    endtask

    task automatic m_step(input bit mv, input bit pl);
        case (m_mode)
            0: begin
                if (pl && m_board[m_sel] == 0) begin
                    m_board[m_sel] = m_turn;
                    m_cnt++;
                    m_elapsed = 0;
                    m_mode = 1;
                end else begin
                    if (mv && !pl) m_sel = (m_sel + 1) % 9;
                    m_elapsed++;
                    if (m_elapsed == T) begin
                        m_turn = 3 - m_turn;
                        m_elapsed = 0;
                    end
                end
            end
            1: begin
                if (m_wins(m_turn)) begin
                    m_win = m_turn; m_mode = 2;
                end else if (m_cnt == 9) begin
                    m_win = 3; m_mode = 2;
                end else begin
                    m_turn = 3 - m_turn; m_elapsed = 0; m_mode = 0;
                end
            end
            default: begin
                if (pl) begin
                    foreach (m_board[i]) m_board[i] = 0;
                    m_sel = 0; m_turn = 1; m_win = 0; m_cnt = 0;
                    m_elapsed = 0; m_mode = 0;
                end
            end
        endcase
    endtask

    // Drive one cycle; a press sampled at edge k takes effect at edge k+2.
    task automatic tick(input bit mv, input bit pl);
        btn_move  = mv;
        btn_place = pl;
        @(posedge clk);
        if (rst) begin
            m_reset();
        end else begin
            m_step(d2_mv, d2_pl);
            d2_mv = d1_mv; d2_pl = d1_pl;
            d1_mv = mv & ~last_mv; d1_pl = pl & ~last_pl;
            last_mv = mv; last_pl = pl;
        end
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic press_move();
        repeat ($urandom_range(1, 2)) tick(1'b1, 1'b0);
        repeat ($urandom_range(1, 2)) tick(1'b0, 1'b0);
    endtask

    task automatic press_place();
        repeat ($urandom_range(1, 3)) tick(1'b0, 1'b1);
        idle(3);
    endtask

    task automatic goto_cell(input int target);
        int n;
        n = (target - m_sel + 9) % 9;
        repeat (n) press_move();
        idle(2);
    endtask

    function automatic logic [17:0] dut_board();
        return {b22, b21, b20, b12, b11, b10, b02, b01, b00};
    endfunction

    function automatic logic [17:0] model_board();
        logic [17:0] v;
        v = '0;
        for (int i = 0; i < 9; i++) v[2*i +: 2] = 2'(m_board[i]);
        return v;
    endfunction

    function automatic logic [30:0] dut_status();
        return {dut_board(), selected, turn, winner, game_over, move_count};
    endfunction

    function automatic logic [30:0] model_status();
        return {model_board(), 4'(m_sel), 2'(m_turn), 2'(m_win),
                (m_mode == 2), 4'(m_cnt)};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        rst = 1'b0;
        idle(3);
        total++; if (dut_board() !== 18'd0) $display("FAIL reset_board: got %h expected 0", dut_board()); else passed++;
        total++; if (selected !== 4'd0) $display("FAIL reset_selected: got %0d expected 0", selected); else passed++;
        total++; if (turn !== 2'b01) $display("FAIL reset_turn: got %b expected 01", turn); else passed++;
        total++; if (winner !== 2'b00) $display("FAIL reset_winner: got %b expected 00", winner); else passed++;
        total++; if (game_over !== 1'b0) $display("FAIL reset_game_over: got %b expected 0", game_over); else passed++;
        total++; if (move_count !== 4'd0) $display("FAIL reset_move_count: got %0d expected 0", move_count); else passed++;
    endtask

    task automatic test_move_wrap();
        repeat (9) press_move();
        idle(2);
        total++; if (selected !== 4'd0) $display("FAIL wrap_selected: got %0d expected 0", selected); else passed++;
        total++; if (turn !== 2'(m_turn)) $display("FAIL wrap_turn: got %b expected %0d", turn, m_turn); else passed++;
        repeat (20) tick(1'b1, 1'b0);
        idle(3);
        total++; if (selected !== 4'd1) $display("FAIL held_move: got %0d expected 1", selected); else passed++;
    endtask

    task automatic test_win();
        int seq [5] = '{0, 3, 1, 4, 2};
        do_reset();
        foreach (seq[i]) begin
            goto_cell(seq[i]);
            press_place();
        end
        total++; if ({b02, b01, b00} !== 6'b010101) $display("FAIL win_row0: got %b expected 010101", {b02, b01, b00}); else passed++;
        total++; if (winner !== 2'b01) $display("FAIL win_winner: got %b expected 01", winner); else passed++;
        total++; if (game_over !== 1'b1) $display("FAIL win_game_over: got %b expected 1", game_over); else passed++;
        total++; if (move_count !== 4'd5) $display("FAIL win_move_count: got %0d expected 5", move_count); else passed++;
        total++; if (dut_board() !== model_board()) $display("FAIL win_board: got %h expected %h", dut_board(), model_board()); else passed++;
        repeat (3) press_move();
        idle(2);
        total++; if (selected !== 4'd2) $display("FAIL over_move_ignored: got %0d expected 2", selected); else passed++;
        total++; if (winner !== 2'b01) $display("FAIL over_winner_frozen: got %b expected 01", winner); else passed++;
    endtask

    task automatic test_restart(input string tag);
        press_place();
        total++; if (dut_board() !== 18'd0) $display("FAIL %s_board: got %h expected 0", tag, dut_board()); else passed++;
        total++; if (turn !== 2'b01) $display("FAIL %s_turn: got %b expected 01", tag, turn); else passed++;
        total++; if ({winner, game_over, move_count, selected} !== 11'd0)
            $display("FAIL %s_flags: got %h expected 0", tag, {winner, game_over, move_count, selected}); else passed++;
    endtask

    task automatic test_occupied();
        goto_cell(4);
        press_place();
        tick(1'b0, 1'b1);
        idle(3);
        total++; if (b11 !== 2'b01) $display("FAIL occ_cell: got %b expected 01", b11); else passed++;
        total++; if (turn !== 2'b10) $display("FAIL occ_turn: got %b expected 10", turn); else passed++;
        total++; if (move_count !== 4'd1) $display("FAIL occ_move_count: got %0d expected 1", move_count); else passed++;
    endtask

    task automatic test_same_cycle();
        goto_cell(2);
        tick(1'b1, 1'b1);
        idle(3);
        total++; if (b02 !== 2'b10) $display("FAIL same_cycle_mark: got %b expected 10", b02); else passed++;
        total++; if (selected !== 4'd2) $display("FAIL same_cycle_sel: got %0d expected 2", selected); else passed++;
        total++; if (move_count !== 4'd2) $display("FAIL same_cycle_count: got %0d expected 2", move_count); else passed++;
    endtask

    task automatic test_timeout();
        do_reset();
        idle(T - 1);
        total++; if (turn !== 2'b01) $display("FAIL timeout_early: got %b expected 01", turn); else passed++;
        idle(1);
        total++; if (turn !== 2'b10) $display("FAIL timeout_toggle: got %b expected 10", turn); else passed++;
        total++; if ({dut_board(), selected} !== 22'd0) $display("FAIL timeout_board: got %h expected 0", {dut_board(), selected}); else passed++;
        idle(T);
        total++; if (turn !== 2'b01) $display("FAIL timeout_second: got %b expected 01", turn); else passed++;
    endtask

    task automatic test_draw();
        int seq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
        do_reset();
        foreach (seq[i]) begin
            goto_cell(seq[i]);
            press_place();
        end
        total++; if (winner !== 2'b11) $display("FAIL draw_winner: got %b expected 11", winner); else passed++;
        total++; if (move_count !== 4'd9) $display("FAIL draw_count: got %0d expected 9", move_count); else passed++;
        total++; if (game_over !== 1'b1) $display("FAIL draw_game_over: got %b expected 1", game_over); else passed++;
        total++; if (dut_board() !== 18'b01_01_10_10_10_01_01_10_01)
            $display("FAIL draw_board: got %b expected 010110101001011001", dut_board()); else passed++;
    endtask

    task automatic test_reset_in_check();
        do_reset();
        tick(1'b0, 1'b1);
        idle(2);
        total++; if (move_count !== 4'd1) $display("FAIL check_pre_count: got %0d expected 1", move_count); else passed++;
        rst = 1'b1;
        tick(1'b0, 1'b0);
        rst = 1'b0;
        total++; if (dut_board() !== 18'd0) $display("FAIL rst_check_board: got %h expected 0", dut_board()); else passed++;
        total++; if (turn !== 2'b01) $display("FAIL rst_check_turn: got %b expected 01", turn); else passed++;
        total++; if ({winner, game_over, move_count, selected} !== 11'd0)
            $display("FAIL rst_check_flags: got %h expected 0", {winner, game_over, move_count, selected}); else passed++;
        idle(3);
        total++; if (dut_status() !== model_status()) $display("FAIL rst_check_settle: got %h expected %h", dut_status(), model_status()); else passed++;
    endtask

    task automatic test_random();
        int a;
        do_reset();
        for (int i = 0; i < 150; i++) begin
            a = int'($urandom_range(0, 9));
            if (a < 6)
                repeat ($urandom_range(1, 4)) tick(1'b1, 1'b0);
            else if (a < 9)
                repeat ($urandom_range(1, 4)) tick(1'b0, 1'b1);
            else
                idle(int'($urandom_range(10, 60)));
            idle(3);
            total++;
            if (dut_status() !== model_status())
                $display("FAIL random[%0d]: got %h expected %h", i, dut_status(), model_status());
            else
                passed++;
        end
    endtask

    initial begin
        rst       = 1'b1;
        btn_move  = 1'b0;
        btn_place = 1'b0;
        m_reset();
        test_reset();
        test_move_wrap();
        test_win();
        test_restart("restart_win");
        test_occupied();
        test_same_cycle();
        test_timeout();
        test_draw();
        test_restart("restart_draw");
        test_reset_in_check();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
